// File: rtl/loader_pkg.sv
//------------------------------------------------------------------------------
// loader_pkg
// Shared definitions for the UART boot loader (irom_uart_loader) and its
// receiver front end (uart_rx).
//   - loader_state_e : frame FSM states
//   - rx_state_e     : serial receiver states
//   - MAGIC_DEFAULT  : default frame start byte
//   - POS_*          : byte positions inside a frame header
//   - clks_per_bit() : bit period in clocks, floored, never below 4
//------------------------------------------------------------------------------
`timescale 1ns/1ps
package loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CNT_LO,
        ST_CNT_HI,
        ST_DATA,
        ST_CSUM,
        ST_DONE,
        ST_ERR
    } loader_state_e;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

    localparam logic [7:0] MAGIC_DEFAULT = 8'hA5;

    // Byte positions of the frame header; data starts at POS_DATA.
    localparam int POS_MAGIC  = 0;
    localparam int POS_CNT_LO = 1;
    localparam int POS_CNT_HI = 2;
    localparam int POS_DATA   = 3;

    localparam int BYTES_PER_WORD   = 4;
    localparam int MIN_CLKS_PER_BIT = 4;

    function automatic int clks_per_bit(input int clk_freq, input int baud);
        int c;
        c = clk_freq / baud;
        return (c < MIN_CLKS_PER_BIT) ? MIN_CLKS_PER_BIT : c;
    endfunction

endpackage

// File: rtl/uart_rx.sv
//------------------------------------------------------------------------------
// uart_rx
// 8N1 serial receiver with a 2-flop input synchronizer and mid-bit sampling.
// Ports:
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   rxd        in   serial line, idle high, asynchronous to clk
//   byte_valid out  one-cycle pulse, byte_data holds a received byte
//   byte_data  out  last received byte (LSB first on the wire)
//   frm_err    out  one-cycle pulse, stop bit was sampled low (byte dropped)
// Parameter CLKS_PER_BIT: bit period in clk cycles (>= 4).
//------------------------------------------------------------------------------
`timescale 1ns/1ps
module uart_rx
    import loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rxd,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frm_err
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

    logic [1:0]       sync_reg;
    logic             rx_prev_reg;
    logic             rx_sync;

    rx_state_e        state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [2:0]       bit_idx_reg, bit_idx_next;
    logic [7:0]       shift_reg, shift_next;
    logic             byte_valid_reg, byte_valid_next;
    logic             frm_err_reg, frm_err_next;

    assign rx_sync = sync_reg[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg       <= 2'b11;
            rx_prev_reg    <= 1'b1;
            state_reg      <= RX_IDLE;
            cnt_reg        <= '0;
            bit_idx_reg    <= '0;
            shift_reg      <= '0;
            byte_valid_reg <= 1'b0;
            frm_err_reg    <= 1'b0;
        end else begin
            sync_reg       <= {sync_reg[0], rxd};
            rx_prev_reg    <= rx_sync;
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            bit_idx_reg    <= bit_idx_next;
            shift_reg      <= shift_next;
            byte_valid_reg <= byte_valid_next;
            frm_err_reg    <= frm_err_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        bit_idx_next    = bit_idx_reg;
        shift_next      = shift_reg;
        byte_valid_next = 1'b0;
        frm_err_next    = 1'b0;
        case (state_reg)
            RX_IDLE: begin
                // Edge, not level: a line held low after a framing error
                // must not look like a new start bit.
                if (rx_prev_reg && !rx_sync) begin
                    state_next = RX_START;
                    cnt_next   = '0;
                end
            end
            RX_START: begin
                if (cnt_reg == HALF_LAST) begin
                    cnt_next     = '0;
                    bit_idx_next = '0;
                    state_next   = rx_sync ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            RX_DATA: begin
                // Counting a full bit from the start-bit centre lands
                // every sample at the centre of the next bit.
                if (cnt_reg == BIT_LAST) begin
                    cnt_next   = '0;
                    shift_next = {rx_sync, shift_reg[7:1]};
                    if (bit_idx_reg == 3'd7) begin
                        state_next = RX_STOP;
                    end else begin
                        bit_idx_next = bit_idx_reg + 3'd1;
                    end
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            RX_STOP: begin
                if (cnt_reg == BIT_LAST) begin
                    cnt_next   = '0;
                    state_next = RX_IDLE;
                    if (rx_sync) begin
                        byte_valid_next = 1'b1;
                    end else begin
                        frm_err_next = 1'b1;
                    end
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            default: state_next = RX_IDLE;
        endcase
    end

    // shift_reg is untouched until the next start bit's first data sample,
    // so it is a stable byte_data for the consumer.
    assign byte_valid = byte_valid_reg;
    assign byte_data  = shift_reg;
    assign frm_err    = frm_err_reg;

endmodule

// File: rtl/irom_uart_loader.sv
//------------------------------------------------------------------------------
// irom_uart_loader
// Boot loader: receives a program image over UART and writes it into the
// instruction ROM write port, holding the CPU in reset until the image is in.
// Frame: MAGIC, CNT_LO, CNT_HI, N little-endian 32-bit words [, CSUM].
// Ports:
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   uart_rxd   in   8N1 serial input, idle high
//   irom_we    out  one-cycle ROM write strobe
//   irom_addr  out  ROM word address
//   irom_wdata out  ROM write data (holds after the strobe)
//   cpu_rst_n  out  CPU reset, released together with load_done
//   load_done  out  image written and accepted
//   load_err   out  last frame rejected
// Optional feature macro: LOADER_CHECKSUM_EN adds a trailing XOR checksum
// byte over all 4N data bytes.
//------------------------------------------------------------------------------
`timescale 1ns/1ps
module irom_uart_loader
    import loader_pkg::*;
#(
    parameter int         CLK_FREQ = 50_000_000,
    parameter int         BAUD     = 115200,
    parameter int         ADDR_W   = 10,
    parameter logic [7:0] MAGIC    = MAGIC_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              uart_rxd,
    output logic              irom_we,
    output logic [ADDR_W-1:0] irom_addr,
    output logic [31:0]       irom_wdata,
    output logic              cpu_rst_n,
    output logic              load_done,
    output logic              load_err
);

    localparam int          CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
    localparam logic [31:0] CAPACITY     = 32'd1 << ADDR_W;

`ifdef LOADER_CHECKSUM_EN
    localparam loader_state_e ST_TAIL = ST_CSUM;
`else
    localparam loader_state_e ST_TAIL = ST_DONE;
`endif

    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_frm_err;

    loader_state_e     state_reg, state_next;
    logic [7:0]        cnt_lo_reg;
    logic [15:0]       words_left_reg;
    logic [23:0]       word_reg;        // first three bytes of the current word
    logic [1:0]        byte_idx_reg;
    logic              irom_we_reg;
    logic [ADDR_W-1:0] irom_addr_reg;
    logic [31:0]       irom_wdata_reg;
    logic              load_done_reg;
    logic              load_err_reg;
    logic              cpu_rst_n_reg;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        csum_reg;
`endif

    logic [15:0] count_full;
    logic [31:0] word_assembled;
    logic        word_last;

    assign count_full     = {rx_data, cnt_lo_reg};
    assign word_assembled = {rx_data, word_reg};
    assign word_last      = (byte_idx_reg == 2'(BYTES_PER_WORD - 1));

    uart_rx #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx (
        .clk        (clk),
        .rst_n      (rst_n),
        .rxd        (uart_rxd),
        .byte_valid (rx_valid),
        .byte_data  (rx_data),
        .frm_err    (rx_frm_err)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (rx_frm_err && (state_reg != ST_IDLE) && (state_reg != ST_DONE)) begin
            state_next = ST_ERR;
        end else if (rx_valid) begin
            case (state_reg)
                ST_IDLE, ST_ERR: begin
                    if (rx_data == MAGIC) state_next = ST_CNT_LO;
                end
                ST_CNT_LO: state_next = ST_CNT_HI;
                ST_CNT_HI: begin
                    // Exactly 2^ADDR_W words is legal and fills the ROM.
                    if ({16'd0, count_full} > CAPACITY) begin
                        state_next = ST_ERR;
                    end else if (count_full == 16'd0) begin
                        state_next = ST_TAIL;
                    end else begin
                        state_next = ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (word_last && (words_left_reg == 16'd1)) state_next = ST_TAIL;
                end
`ifdef LOADER_CHECKSUM_EN
                ST_CSUM: state_next = (rx_data == csum_reg) ? ST_DONE : ST_ERR;
`endif
                default: state_next = state_reg;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_lo_reg     <= '0;
            words_left_reg <= '0;
            word_reg       <= '0;
            byte_idx_reg   <= '0;
            irom_we_reg    <= 1'b0;
            irom_addr_reg  <= '0;
            irom_wdata_reg <= '0;
            load_done_reg  <= 1'b0;
            load_err_reg   <= 1'b0;
            cpu_rst_n_reg  <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            csum_reg       <= '0;
`endif
        end else begin
            irom_we_reg <= 1'b0;
            // Address advances the cycle after the strobe so it is stable
            // while irom_we is high.
            if (irom_we_reg) begin
                irom_addr_reg <= irom_addr_reg + ADDR_W'(1);
            end
            if (rx_valid) begin
                case (state_reg)
                    ST_IDLE, ST_ERR: begin
                        if (rx_data == MAGIC) begin
                            irom_addr_reg <= '0;
                            byte_idx_reg  <= '0;
`ifdef LOADER_CHECKSUM_EN
                            csum_reg      <= '0;
`endif
                        end
                    end
                    ST_CNT_LO: cnt_lo_reg <= rx_data;
                    ST_CNT_HI: words_left_reg <= count_full;
                    ST_DATA: begin
                        word_reg     <= {rx_data, word_reg[23:8]};
                        byte_idx_reg <= byte_idx_reg + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                        csum_reg     <= csum_reg ^ rx_data;
`endif
                        if (word_last) begin
                            irom_we_reg    <= 1'b1;
                            irom_wdata_reg <= word_assembled;
                            words_left_reg <= words_left_reg - 16'd1;
                        end
                    end
                    default: ;
                endcase
            end
            // Status flags follow the next state directly so they change
            // on the same edge as the state register.
            load_done_reg <= (state_next == ST_DONE);
            cpu_rst_n_reg <= (state_next == ST_DONE);
            load_err_reg  <= (state_next == ST_ERR);
        end
    end

    assign irom_we    = irom_we_reg;
    assign irom_addr  = irom_addr_reg;
    assign irom_wdata = irom_wdata_reg;
    assign load_done  = load_done_reg;
    assign load_err   = load_err_reg;
    assign cpu_rst_n  = cpu_rst_n_reg;

endmodule

// File: tb/tb_irom_uart_loader.sv
`timescale 1ns/1ps
module tb_irom_uart_loader;
    import loader_pkg::*;

    localparam int         CLK_FREQ = 1_600_000;
    localparam int         BAUD     = 100_000;
    localparam int         ADDR_W   = 10;
    localparam int         CPB      = CLK_FREQ / BAUD;
    localparam int         GAP      = 4;
    localparam logic [7:0] MAGIC_B  = 8'hA5;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              uart_rxd = 1'b1;
    logic              irom_we;
    logic [ADDR_W-1:0] irom_addr;
    logic [31:0]       irom_wdata;
    logic              cpu_rst_n;
    logic              load_done;
    logic              load_err;

    int errors = 0;
    int checks = 0;

    // Reference model: the frame to send, and the ROM writes it must cause.
    logic [7:0]        frame_q[$];
    logic [ADDR_W+31:0] exp_q[$];
    logic [ADDR_W+31:0] obs_q[$];
    logic [7:0]        model_csum;
    int                pair_bad = 0;

    irom_uart_loader #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD),
        .ADDR_W   (ADDR_W),
        .MAGIC    (MAGIC_B)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .uart_rxd   (uart_rxd),
        .irom_we    (irom_we),
        .irom_addr  (irom_addr),
        .irom_wdata (irom_wdata),
        .cpu_rst_n  (cpu_rst_n),
        .load_done  (load_done),
        .load_err   (load_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (irom_we === 1'b1) obs_q.push_back({irom_addr, irom_wdata});
        if (load_done !== cpu_rst_n) pair_bad++;
    end

    task automatic send_byte(input logic [7:0] b, input logic stop_bit, input int gap);
        uart_rxd = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rxd = b[i];
            repeat (CPB) @(negedge clk);
        end
        uart_rxd = stop_bit;
        repeat (CPB) @(negedge clk);
        uart_rxd = 1'b1;
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_range(input int first, input int last, input int gap);
        for (int i = first; i <= last; i++) send_byte(frame_q[i], 1'b1, gap);
    endtask

    task automatic start_frame(input int n);
        logic [7:0] hdr [POS_DATA];
        hdr[POS_MAGIC]  = MAGIC_B;
        hdr[POS_CNT_LO] = n[7:0];
        hdr[POS_CNT_HI] = n[15:8];
        frame_q.delete();
        exp_q.delete();
        model_csum = 8'h00;
        for (int i = 0; i < POS_DATA; i++) frame_q.push_back(hdr[i]);
    endtask

    task automatic add_word(input logic [31:0] w);
        for (int k = 0; k < BYTES_PER_WORD; k++) begin
            frame_q.push_back(w[8*k +: 8]);
            model_csum = model_csum ^ w[8*k +: 8];
        end
        exp_q.push_back({ADDR_W'(exp_q.size()), w});
    endtask

    task automatic end_frame();
`ifdef LOADER_CHECKSUM_EN
        frame_q.push_back(model_csum);
`endif
    endtask

    task automatic random_frame(input int n);
        start_frame(n);
        for (int i = 0; i < n; i++) add_word($urandom);
        end_frame();
    endtask

    task automatic do_reset();
        uart_rxd = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        obs_q.delete();
        pair_bad = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (irom_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b expected 0", irom_we); end
        checks++; if (irom_addr !== '0) begin errors++; $display("FAIL reset_addr: got %0d expected 0", irom_addr); end
        checks++; if (irom_wdata !== 32'h0) begin errors++; $display("FAIL reset_wdata: got %h expected 0", irom_wdata); end
        checks++; if (cpu_rst_n !== 1'b0) begin errors++; $display("FAIL reset_cpu_rst_n: got %b expected 0", cpu_rst_n); end
        checks++; if (load_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", load_done); end
        checks++; if (load_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", load_err); end
        $display("test_reset: outputs at reset checked");
    endtask

    task automatic test_basic_frame();
        do_reset();
        start_frame(2);
        add_word(32'h00000013);
        add_word(32'h00100093);
        end_frame();
        send_range(0, frame_q.size() - 2, GAP);
        checks++; if (load_done !== 1'b0) begin errors++; $display("FAIL basic_early_done: got %b expected 0", load_done); end
        send_range(frame_q.size() - 1, frame_q.size() - 1, 0);
        checks++; if (load_done !== 1'b1) begin errors++; $display("FAIL basic_done: got %b expected 1", load_done); end
        checks++; if (cpu_rst_n !== 1'b1) begin errors++; $display("FAIL basic_cpu_rst_n: got %b expected 1", cpu_rst_n); end
        checks++; if (load_err !== 1'b0) begin errors++; $display("FAIL basic_err: got %b expected 0", load_err); end
        checks++; if (pair_bad !== 0) begin errors++; $display("FAIL basic_pair: got %0d mismatched cycles expected 0", pair_bad); end
        checks++; if (irom_wdata !== 32'h00100093) begin errors++; $display("FAIL basic_wdata_hold: got %h expected 00100093", irom_wdata); end
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++; $display("FAIL basic_wcount: got %0d writes expected %0d", obs_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                checks++;
                if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL basic_write%0d: got %h expected %h", i, obs_q[i], exp_q[i]); end
            end
        end
        $display("test_basic_frame: %0d bytes sent, %0d writes seen", frame_q.size(), obs_q.size());
    endtask

    task automatic test_garbage_prefix();
        do_reset();
        send_byte(8'h00, 1'b1, GAP);
        send_byte(8'hFF, 1'b1, GAP);
        send_byte(8'h5A, 1'b1, GAP);
        start_frame(1);
        add_word(32'hDEADBEEF);
        end_frame();
        send_range(0, frame_q.size() - 1, GAP);
        checks++; if (load_done !== 1'b1) begin errors++; $display("FAIL garbage_done: got %b expected 1", load_done); end
        checks++;
        if (obs_q.size() != 1) begin
            errors++; $display("FAIL garbage_wcount: got %0d writes expected 1", obs_q.size());
        end else begin
            checks++;
            if (obs_q[0] !== exp_q[0]) begin errors++; $display("FAIL garbage_write: got %h expected %h", obs_q[0], exp_q[0]); end
        end
        $display("test_garbage_prefix: %0d writes seen", obs_q.size());
    endtask

`ifdef LOADER_CHECKSUM_EN
    task automatic test_bad_csum();
        do_reset();
        start_frame(1);
        add_word(32'h04030201);
        frame_q.push_back(8'h00);
        send_range(0, frame_q.size() - 1, GAP);
        checks++; if (load_err !== 1'b1) begin errors++; $display("FAIL csum_err: got %b expected 1", load_err); end
        checks++; if (cpu_rst_n !== 1'b0) begin errors++; $display("FAIL csum_cpu_rst_n: got %b expected 0", cpu_rst_n); end
        checks++; if (load_done !== 1'b0) begin errors++; $display("FAIL csum_done: got %b expected 0", load_done); end
        checks++;
        if ((obs_q.size() != 1) || (obs_q[0] !== exp_q[0])) begin
            errors++; $display("FAIL csum_write: got %0d writes expected one write of %h", obs_q.size(), exp_q[0]);
        end
        obs_q.delete();
        random_frame(2);
        send_range(0, frame_q.size() - 1, GAP);
        checks++; if (load_err !== 1'b0) begin errors++; $display("FAIL csum_recover_err: got %b expected 0", load_err); end
        checks++; if (load_done !== 1'b1) begin errors++; $display("FAIL csum_recover_done: got %b expected 1", load_done); end
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++; $display("FAIL csum_recover_wcount: got %0d writes expected %0d", obs_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                checks++;
                if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL csum_recover_write%0d: got %h expected %h", i, obs_q[i], exp_q[i]); end
            end
        end
        $display("test_bad_csum: rejected frame then reload, %0d writes on reload", obs_q.size());
    endtask
`endif

    task automatic test_oversize_count();
        do_reset();
        send_byte(MAGIC_B, 1'b1, GAP);
        send_byte(8'h01, 1'b1, GAP);
        send_byte(8'h04, 1'b1, GAP);
        checks++; if (load_err !== 1'b1) begin errors++; $display("FAIL oversize_err: got %b expected 1", load_err); end
        checks++; if (cpu_rst_n !== 1'b0) begin errors++; $display("FAIL oversize_cpu_rst_n: got %b expected 0", cpu_rst_n); end
        for (int i = 0; i < BYTES_PER_WORD; i++) send_byte(8'(i + 8'h10), 1'b1, GAP);
        checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL oversize_wcount: got %0d writes expected 0", obs_q.size()); end
        checks++; if (load_done !== 1'b0) begin errors++; $display("FAIL oversize_done: got %b expected 0", load_done); end
        $display("test_oversize_count: count 0x0401 sent");
    endtask

    task automatic test_frame_error();
        do_reset();
        send_byte(MAGIC_B, 1'b1, GAP);
        send_byte(8'h01, 1'b1, GAP);
        send_byte(8'h00, 1'b1, GAP);
        send_byte(8'hAA, 1'b1, GAP);
        send_byte(8'hBB, 1'b0, GAP);
        checks++; if (load_err !== 1'b1) begin errors++; $display("FAIL frmerr_err: got %b expected 1", load_err); end
        checks++; if (cpu_rst_n !== 1'b0) begin errors++; $display("FAIL frmerr_cpu_rst_n: got %b expected 0", cpu_rst_n); end
        send_byte(8'hCC, 1'b1, GAP);
        send_byte(8'hDD, 1'b1, GAP);
        checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL frmerr_wcount: got %0d writes expected 0", obs_q.size()); end
        random_frame(1);
        send_range(0, frame_q.size() - 1, GAP);
        checks++; if (load_done !== 1'b1 || load_err !== 1'b0) begin errors++; $display("FAIL frmerr_recover: got done=%b err=%b expected done=1 err=0", load_done, load_err); end
        checks++;
        if ((obs_q.size() != 1) || (obs_q[0] !== exp_q[0])) begin
            errors++; $display("FAIL frmerr_recover_write: got %0d writes expected one write of %h", obs_q.size(), exp_q[0]);
        end
        $display("test_frame_error: stop bit low in data byte 2, then reload");
    endtask

    task automatic test_zero_count();
        do_reset();
        start_frame(0);
        end_frame();
        send_range(0, frame_q.size() - 1, GAP);
        checks++; if (load_done !== 1'b1) begin errors++; $display("FAIL zero_done: got %b expected 1", load_done); end
        checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL zero_wcount: got %0d writes expected 0", obs_q.size()); end
        $display("test_zero_count: empty image sent");
    endtask

    task automatic test_reset_midframe();
        do_reset();
        random_frame(3);
        send_range(0, POS_DATA + BYTES_PER_WORD + 1, GAP);
        checks++;
        if ((obs_q.size() != 1) || (obs_q[0] !== exp_q[0])) begin
            errors++; $display("FAIL mid_first_word: got %0d writes expected one write of %h", obs_q.size(), exp_q[0]);
        end
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({irom_we, irom_addr, irom_wdata, cpu_rst_n, load_done, load_err} !== '0) begin
            errors++; $display("FAIL mid_reset_outputs: got we=%b addr=%0d wdata=%h cpu_rst_n=%b done=%b err=%b expected all 0",
                              irom_we, irom_addr, irom_wdata, cpu_rst_n, load_done, load_err);
        end
        do_reset();
        random_frame(3);
        send_range(0, frame_q.size() - 1, GAP);
        checks++; if (load_done !== 1'b1) begin errors++; $display("FAIL mid_reload_done: got %b expected 1", load_done); end
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++; $display("FAIL mid_reload_wcount: got %0d writes expected %0d", obs_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                checks++;
                if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL mid_reload_write%0d: got %h expected %h", i, obs_q[i], exp_q[i]); end
            end
        end
        $display("test_reset_midframe: reset in word 1, reload %0d writes", obs_q.size());
    endtask

    task automatic test_back_to_back();
        for (int t = 0; t < 4; t++) begin
            int n;
            int gap;
            logic [7:0] g;
            do_reset();
            n   = $urandom_range(1, 5);
            gap = (t % 2 == 0) ? 0 : GAP;
            for (int j = 0; j < t; j++) begin
                g = 8'($urandom);
                if (g == MAGIC_B) g = 8'h5A;
                send_byte(g, 1'b1, gap);
            end
            random_frame(n);
            send_range(0, frame_q.size() - 1, gap);
            checks++; if (load_done !== 1'b1 || load_err !== 1'b0) begin errors++; $display("FAIL b2b%0d_status: got done=%b err=%b expected done=1 err=0", t, load_done, load_err); end
            checks++; if (pair_bad !== 0) begin errors++; $display("FAIL b2b%0d_pair: got %0d mismatched cycles expected 0", t, pair_bad); end
            checks++;
            if (obs_q.size() != exp_q.size()) begin
                errors++; $display("FAIL b2b%0d_wcount: got %0d writes expected %0d", t, obs_q.size(), exp_q.size());
            end else begin
                foreach (exp_q[i]) begin
                    checks++;
                    if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL b2b%0d_write%0d: got %h expected %h", t, i, obs_q[i], exp_q[i]); end
                end
            end
            $display("test_back_to_back: frame %0d, %0d words, gap %0d, %0d writes", t, n, gap, obs_q.size());
        end
    endtask

    task automatic test_done_terminal();
        do_reset();
        random_frame(1);
        send_range(0, frame_q.size() - 1, GAP);
        obs_q.delete();
        random_frame(2);
        send_range(0, frame_q.size() - 1, GAP);
        checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL done_terminal_wcount: got %0d writes expected 0", obs_q.size()); end
        checks++; if (load_done !== 1'b1 || cpu_rst_n !== 1'b1) begin errors++; $display("FAIL done_terminal_status: got done=%b cpu_rst_n=%b expected 1 1", load_done, cpu_rst_n); end
        $display("test_done_terminal: second frame after done sent");
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_garbage_prefix();
`ifdef LOADER_CHECKSUM_EN
        test_bad_csum();
`endif
        test_oversize_count();
        test_frame_error();
        test_zero_count();
        test_reset_midframe();
        test_back_to_back();
        test_done_terminal();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
